// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared types and constants for the sequential divider.
// Holds the default width, FSM state enum and overflow bit positions.
package seq_div_pkg;

   localparam int WIDTH_DEF = 32;

   localparam int OVF_DZ = 0;
   localparam int OVF_SO = 1;

   localparam logic [1:0] OVF_DZ_M = 2'(1 << OVF_DZ);
   localparam logic [1:0] OVF_SO_M = 2'(1 << OVF_SO);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_div_sub_borrow.sv
// sub_borrow: N-bit subtractor, diff = a - b, borrow = (a < b).
// Ports: a, b (N) in; diff (N), borrow (1) out.
module sub_borrow #(
   parameter int N = 33
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);

   assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_div.sv
// seq_div: restoring divider, one quotient bit per clock, valid/ready I/O.
// Ports: clk, rst_n, in_valid/in_ready, x, y, out_valid/out_ready,
// quoc, resto, overflow[1:0]; sgn only with SEQ_DIV_SIGNED_EN defined.
module seq_div
   import seq_div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quoc,
   output logic [WIDTH-1:0] resto,
   output logic [1:0]       overflow
`ifdef SEQ_DIV_SIGNED_EN
   ,
   input  logic             sgn
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic             neg_q;
   logic             neg_r;
   logic             so;

   logic [WIDTH-1:0] ax;
   logic [WIDTH-1:0] ay;
   logic             a_nq;
   logic             a_nr;
   logic             a_so;

   logic [WIDTH:0]   shf;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic [WIDTH-1:0] qn;
   logic [WIDTH-1:0] rn;
   logic             acc;

`ifdef SEQ_DIV_SIGNED_EN
   // Divide magnitudes; signs are reapplied when the result is loaded.
   assign a_nq = sgn & (x[WIDTH-1] ^ y[WIDTH-1]);
   assign a_nr = sgn & x[WIDTH-1];
   assign ax   = a_nr ? -x : x;
   assign ay   = (sgn & y[WIDTH-1]) ? -y : y;
   assign a_so = sgn && (x == {1'b1, {(WIDTH-1){1'b0}}})
                 && (y == '1);
`else
   assign a_nq = 1'b0;
   assign a_nr = 1'b0;
   assign ax   = x;
   assign ay   = y;
   assign a_so = 1'b0;
`endif

   assign acc = in_valid & in_ready;

   // dvd shifts left; its MSB feeds the partial remainder, and the
   // freed LSB collects the quotient bit.
   assign shf = {rem, dvd[WIDTH-1]};

   sub_borrow #(
      .N(WIDTH + 1)
   ) u_sub (
      .a     (shf),
      .b     ({1'b0, dvs}),
      .diff  (diff),
      .borrow(borrow)
   );

   assign qn = {dvd[WIDTH-2:0], ~borrow};
   assign rn = borrow ? shf[WIDTH-1:0] : diff[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         quoc      <= '0;
         resto     <= '0;
         overflow  <= '0;
         cnt       <= '0;
         rem       <= '0;
         dvd       <= '0;
         dvs       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         so        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (acc) begin
                  dvd      <= ax;
                  dvs      <= ay;
                  rem      <= '0;
                  cnt      <= '0;
                  neg_q    <= a_nq;
                  neg_r    <= a_nr;
                  so       <= a_so;
                  in_ready <= 1'b0;
                  if (y == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     quoc      <= '1;
                     resto     <= x;
                     overflow  <= OVF_DZ_M;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem <= rn;
               dvd <= qn;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  quoc      <= neg_q ? -qn : qn;
                  resto     <= neg_r ? -rn : rn;
                  overflow  <= so ? OVF_SO_M : '0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed + random checks of seq_div against an arithmetic
// reference model (latency, results, stall hold, reset, back-to-back).
module tb_seq_div;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] x = '0;
   logic [W-1:0] y = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] quoc;
   logic [W-1:0] resto;
   logic [1:0]   overflow;
   logic         sgn = 1'b0;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_div #(
      .WIDTH(W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x        (x),
      .y        (y),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .quoc     (quoc),
      .resto    (resto),
      .overflow (overflow)
`ifdef SEQ_DIV_SIGNED_EN
      ,
      .sgn      (sgn)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic on the currently driven x, y, sgn.
   task automatic model(output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic [1:0] o);
      if (y == 0) begin
         q = '1;
         r = x;
         o = 2'b01;
      end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         q = x;
         r = '0;
         o = 2'b10;
      end else if (sgn) begin
         q = W'($signed(x) / $signed(y));
         r = W'($signed(x) % $signed(y));
         o = 2'b00;
      end else begin
         q = x / y;
         r = x % y;
         o = 2'b00;
      end
   endtask

   // Called at a negedge. b2b keeps in_valid high and out_ready high.
   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic s, input int stall, input bit b2b);
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic [1:0]   eo;
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_idle", 64'(in_ready), 64'd1);
      x = a;
      y = b;
      sgn = s;
      in_valid = 1'b1;
      model(eq, er, eo);
      @(posedge clk);
      #1;
      if (!b2b) begin
         in_valid = 1'b0;
         x = $urandom;
         y = $urandom;
         sgn = ~s;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 100);
      chk("latency", 64'(n), (b == 0) ? 64'd1 : 64'(W + 1));
      chk("quoc", 64'(quoc), 64'(eq));
      chk("resto", 64'(resto), 64'(er));
      chk("overflow", 64'(overflow), 64'(eo));
      chk("busy_rdy", 64'(in_ready), 64'd0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("hold_q", 64'(quoc), 64'(eq));
         chk("hold_r", 64'(resto), 64'(er));
         chk("hold_ovf", 64'(overflow), 64'(eo));
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_rdy", 64'(in_ready), 64'd0);
      end
      if (!b2b) begin
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk("post_valid", 64'(out_valid), 64'd0);
         chk("post_rdy", 64'(in_ready), 64'd1);
      end
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rdy", 64'(in_ready), 64'd1);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_q", 64'(quoc), 64'd0);
      chk("rst_r", 64'(resto), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      op(32'd100, 32'd7, 1'b0, 0, 1'b0);
      op(32'd5, 32'd0, 1'b0, 0, 1'b0);
      op(32'd100, 32'd7, 1'b0, 10, 1'b0);
      op(32'd0, 32'd1, 1'b0, 0, 1'b0);
      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
      op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0);
      op(32'd3, 32'd10, 1'b0, 0, 1'b0);
      op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         op(ra, rb, 1'b0, $urandom_range(0, 2), 1'b0);
      end

`ifdef SEQ_DIV_SIGNED_EN
      op(-32'sd7, 32'd2, 1'b1, 0, 1'b0);
      op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
      op(32'd7, -32'sd2, 1'b1, 0, 1'b0);
      op(-32'sd9, 32'd0, 1'b1, 0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         op(ra, rb, 1'b1, 0, 1'b0);
      end
`endif

      // Reset in the middle of CALC.
      x = $urandom;
      y = $urandom | 32'd1;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (12) @(negedge clk);
      chk("calc_valid", 64'(out_valid), 64'd0);
      chk("calc_rdy", 64'(in_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_rdy", 64'(in_ready), 64'd1);
      chk("arst_q", 64'(quoc), 64'd0);
      chk("arst_r", 64'(resto), 64'd0);
      chk("arst_ovf", 64'(overflow), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      op(32'd9, 32'd3, 1'b0, 0, 1'b0);

      // Back-to-back with in_valid and out_ready held high.
      out_ready = 1'b1;
      op(32'd1000, 32'd9, 1'b0, 0, 1'b1);
      op(32'd77, 32'd0, 1'b0, 0, 1'b1);
      op(32'hDEAD_BEEF, 32'd16, 1'b0, 0, 1'b1);
      op(32'd12, 32'd12, 1'b0, 0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("b2b_end_rdy", 64'(in_ready), 64'd1);
      chk("b2b_end_valid", 64'(out_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
